// File: rtl/rtc_resp_pkg.sv
// Shared definitions for the RTC bus responder: register map, BCD field limits
// and the bus handshake state encoding.
package rtc_resp_pkg;

  localparam logic [7:0] ADDR_STATUS    = 8'h00;
  localparam logic [7:0] ADDR_SEC       = 8'h21;
  localparam logic [7:0] ADDR_MIN       = 8'h22;
  localparam logic [7:0] ADDR_HOUR      = 8'h23;
  localparam logic [7:0] ADDR_DAY       = 8'h24;
  localparam logic [7:0] ADDR_MONTH     = 8'h25;
  localparam logic [7:0] ADDR_YEAR      = 8'h26;
  localparam logic [7:0] ADDR_TMR_SEC   = 8'h41;
  localparam logic [7:0] ADDR_TMR_MIN   = 8'h42;
  localparam logic [7:0] ADDR_TMR_HOUR  = 8'h43;

  localparam logic [7:0] BCD_ZERO       = 8'h00;
  localparam logic [7:0] BCD_ONE        = 8'h01;
  localparam logic [7:0] BCD_MINSEC_MAX = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_DAY_MAX    = 8'h31;
  localparam logic [7:0] BCD_MONTH_MAX  = 8'h12;
  localparam logic [7:0] BCD_YEAR_MAX   = 8'h99;

  localparam logic [7:0] UNMAPPED_DATA  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA
  } bus_state_t;

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD field with bus load, count up/down between MIN_VAL and MAX_VAL,
// and a wrap flag that serves as carry (counting up) or borrow (counting down).
module bcd_pair_cnt
  import rtc_resp_pkg::*;
#(
  parameter logic [7:0] MIN_VAL = BCD_ZERO,
  parameter logic [7:0] MAX_VAL = BCD_MINSEC_MAX,
  parameter logic [7:0] RST_VAL = BCD_ZERO
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [7:0] o_val,
  output logic       o_wrap
);
  logic [7:0] r_val;
  logic [7:0] w_up;
  logic [7:0] w_down;

  // Range compares use >= / <= so an illegal loaded value folds back on its next step.
  always_comb begin
    w_up   = {r_val[7:4], r_val[3:0] + 4'd1};
    w_down = {r_val[7:4], r_val[3:0] - 4'd1};
    if (r_val >= MAX_VAL) begin
      w_up = MIN_VAL;
    end else if (r_val[3:0] >= 4'd9) begin
      w_up = {r_val[7:4] + 4'd1, 4'd0};
    end
    if (r_val <= MIN_VAL) begin
      w_down = MAX_VAL;
    end else if (r_val[3:0] == 4'd0) begin
      w_down = {r_val[7:4] - 4'd1, 4'd9};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val <= RST_VAL;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_inc) begin
      r_val <= w_up;
    end else if (i_dec) begin
      r_val <= w_down;
    end
  end

  assign o_val  = r_val;
  assign o_wrap = (i_inc && (r_val >= MAX_VAL)) || (i_dec && (r_val <= MIN_VAL));

endmodule

// File: rtl/rtc_bus_responder.sv
// Real-time clock and countdown timer behind a multiplexed address/data bus
// with asynchronous control strobes.
module rtc_bus_responder
  import rtc_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       CSI,
  input  logic       ADI,
  input  logic       WRI,
  input  logic       RDI,
  inout  wire  [7:0] Bus_Dato_Dir,
  input  logic       tick_1s,
  output logic       irq_n
);
  logic [3:0]  r_sync [SYNC_STAGES];
  logic        w_cs, w_ad, w_wr, w_rd;
  logic        r_wr_prev, r_rd_prev;
  logic        w_wr_fall, w_wr_rise, w_rd_fall, w_rd_rise;
  bus_state_t  r_state;
  logic [7:0]  r_addr_q, r_rd_buf, w_rd_mux;
  logic        w_wr_en;
  logic        r_tick_pend, w_tick_go;
  logic        r_timer_done;
  logic        w_tmr_run, w_tmr_expire;
  logic [7:0]  w_sec, w_min, w_hour, w_day, w_month, w_year;
  logic [7:0]  w_tsec, w_tmin, w_thour;
  logic        w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_wrap, w_month_wrap, w_year_wrap;
  logic        w_tsec_wrap, w_tmin_wrap, w_thour_wrap;
  logic        w_unused_ok;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'hF;
    end else begin
      r_sync[0] <= {CSI, ADI, WRI, RDI};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign {w_cs, w_ad, w_wr, w_rd} = r_sync[SYNC_STAGES-1];
  assign w_wr_fall = r_wr_prev & ~w_wr;
  assign w_wr_rise = ~r_wr_prev & w_wr;
  assign w_rd_fall = r_rd_prev & ~w_rd;
  assign w_rd_rise = ~r_rd_prev & w_rd;
  assign w_wr_en   = (r_state == ST_WR_DATA) && !w_cs && w_wr_rise;

  always_comb begin
    case (r_addr_q)
      ADDR_STATUS:   w_rd_mux = {7'd0, r_timer_done};
      ADDR_SEC:      w_rd_mux = w_sec;
      ADDR_MIN:      w_rd_mux = w_min;
      ADDR_HOUR:     w_rd_mux = w_hour;
      ADDR_DAY:      w_rd_mux = w_day;
      ADDR_MONTH:    w_rd_mux = w_month;
      ADDR_YEAR:     w_rd_mux = w_year;
      ADDR_TMR_SEC:  w_rd_mux = w_tsec;
      ADDR_TMR_MIN:  w_rd_mux = w_tmin;
      ADDR_TMR_HOUR: w_rd_mux = w_thour;
      default:       w_rd_mux = UNMAPPED_DATA;
    endcase
  end

  // Chip-select release takes precedence in every phase so an aborted cycle never writes.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_addr_q  <= 8'h00;
      r_rd_buf  <= 8'h00;
      r_wr_prev <= 1'b1;
      r_rd_prev <= 1'b1;
    end else begin
      r_wr_prev <= w_wr;
      r_rd_prev <= w_rd;
      case (r_state)
        ST_IDLE: begin
          if (!w_cs && w_wr_fall) begin
            r_state <= w_ad ? ST_WR_DATA : ST_ADDR;
          end else if (!w_cs && w_ad && w_rd_fall) begin
            r_state  <= ST_RD_DATA;
            r_rd_buf <= w_rd_mux;
          end
        end
        ST_ADDR: begin
          if (w_cs) begin
            r_state <= ST_IDLE;
          end else if (w_wr_rise) begin
            r_addr_q <= Bus_Dato_Dir;
            r_state  <= ST_IDLE;
          end
        end
        ST_WR_DATA: if (w_cs || w_wr_rise) r_state <= ST_IDLE;
        ST_RD_DATA: if (w_cs || w_rd_rise) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign Bus_Dato_Dir = (r_state == ST_RD_DATA) ? r_rd_buf : 8'hzz;

  // A tick colliding with a bus write is deferred by one cycle rather than dropped.
  assign w_tick_go    = (tick_1s || r_tick_pend) && !w_wr_en;
  assign w_tmr_run    = w_tick_go && ((w_thour | w_tmin | w_tsec) != 8'h00);
  assign w_tmr_expire = w_tmr_run && (w_thour == BCD_ZERO) && (w_tmin == BCD_ZERO)
                        && (w_tsec == BCD_ONE);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_tick_pend  <= 1'b0;
      r_timer_done <= 1'b0;
    end else begin
      r_tick_pend <= w_wr_en ? (tick_1s || r_tick_pend) : (tick_1s && r_tick_pend);
      if (w_wr_en && (r_addr_q == ADDR_STATUS)) begin
        r_timer_done <= 1'b0;
      end else if (w_tmr_expire) begin
        r_timer_done <= 1'b1;
      end
    end
  end

  assign irq_n = ~r_timer_done;

  bcd_pair_cnt #(.MIN_VAL(BCD_ZERO), .MAX_VAL(BCD_MINSEC_MAX), .RST_VAL(BCD_ZERO)) u_sec (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_SEC)),
    .i_load_val(Bus_Dato_Dir), .i_inc(w_tick_go), .i_dec(1'b0), .o_val(w_sec), .o_wrap(w_sec_wrap));
  bcd_pair_cnt #(.MIN_VAL(BCD_ZERO), .MAX_VAL(BCD_MINSEC_MAX), .RST_VAL(BCD_ZERO)) u_min (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_MIN)),
    .i_load_val(Bus_Dato_Dir), .i_inc(w_sec_wrap), .i_dec(1'b0), .o_val(w_min), .o_wrap(w_min_wrap));
  bcd_pair_cnt #(.MIN_VAL(BCD_ZERO), .MAX_VAL(BCD_HOUR_MAX), .RST_VAL(BCD_ZERO)) u_hour (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_HOUR)),
    .i_load_val(Bus_Dato_Dir), .i_inc(w_min_wrap), .i_dec(1'b0), .o_val(w_hour), .o_wrap(w_hour_wrap));
  bcd_pair_cnt #(.MIN_VAL(BCD_ONE), .MAX_VAL(BCD_DAY_MAX), .RST_VAL(BCD_ONE)) u_day (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_DAY)),
    .i_load_val(Bus_Dato_Dir), .i_inc(w_hour_wrap), .i_dec(1'b0), .o_val(w_day), .o_wrap(w_day_wrap));
  bcd_pair_cnt #(.MIN_VAL(BCD_ONE), .MAX_VAL(BCD_MONTH_MAX), .RST_VAL(BCD_ONE)) u_month (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_MONTH)),
    .i_load_val(Bus_Dato_Dir), .i_inc(w_day_wrap), .i_dec(1'b0), .o_val(w_month), .o_wrap(w_month_wrap));
  bcd_pair_cnt #(.MIN_VAL(BCD_ZERO), .MAX_VAL(BCD_YEAR_MAX), .RST_VAL(BCD_ZERO)) u_year (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_YEAR)),
    .i_load_val(Bus_Dato_Dir), .i_inc(w_month_wrap), .i_dec(1'b0), .o_val(w_year), .o_wrap(w_year_wrap));

  bcd_pair_cnt #(.MIN_VAL(BCD_ZERO), .MAX_VAL(BCD_MINSEC_MAX), .RST_VAL(BCD_ZERO)) u_tsec (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_TMR_SEC)),
    .i_load_val(Bus_Dato_Dir), .i_inc(1'b0), .i_dec(w_tmr_run), .o_val(w_tsec), .o_wrap(w_tsec_wrap));
  bcd_pair_cnt #(.MIN_VAL(BCD_ZERO), .MAX_VAL(BCD_MINSEC_MAX), .RST_VAL(BCD_ZERO)) u_tmin (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_TMR_MIN)),
    .i_load_val(Bus_Dato_Dir), .i_inc(1'b0), .i_dec(w_tsec_wrap), .o_val(w_tmin), .o_wrap(w_tmin_wrap));
  bcd_pair_cnt #(.MIN_VAL(BCD_ZERO), .MAX_VAL(BCD_HOUR_MAX), .RST_VAL(BCD_ZERO)) u_thour (
    .i_clk(CLK), .i_rst_n(Reset), .i_load(w_wr_en && (r_addr_q == ADDR_TMR_HOUR)),
    .i_load_val(Bus_Dato_Dir), .i_inc(1'b0), .i_dec(w_tmin_wrap), .o_val(w_thour), .o_wrap(w_thour_wrap));

  // Year rollover and timer-hour borrow have nowhere further to propagate.
  assign w_unused_ok = &{1'b0, w_year_wrap, w_thour_wrap};

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder: drives bus handshakes through the
// synchronizers and checks register contents, read timing and the timer interrupt.
module tb_rtc_bus_responder;
  import rtc_resp_pkg::*;

  localparam int SYNC = 2;

  logic       clk     = 1'b0;
  logic       resetN  = 1'b0;
  logic       csi     = 1'b1;
  logic       adi     = 1'b0;
  logic       wri     = 1'b1;
  logic       rdi     = 1'b1;
  logic       tick1s  = 1'b0;
  logic [7:0] tbBus   = 8'h00;
  logic       tbBusEn = 1'b0;
  logic       irqN;
  tri1  [7:0] busLine;
  int         checkCount = 0;
  int         passCount  = 0;

  assign busLine = tbBusEn ? tbBus : 8'hzz;

  always #5 clk = ~clk;

  rtc_bus_responder #(.SYNC_STAGES(SYNC)) dut (
    .CLK(clk), .Reset(resetN), .CSI(csi), .ADI(adi), .WRI(wri), .RDI(rdi),
    .Bus_Dato_Dir(busLine), .tick_1s(tick1s), .irq_n(irqN)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %02h expected %02h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic cs, input logic ad, input logic wr, input logic rd);
    @(negedge clk);
    csi = cs; adi = ad; wri = wr; rdi = rd;
  endtask

  task automatic writeAddr(input logic [7:0] addr);
    tbBus = addr; tbBusEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
    tbBusEn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic writeData(input logic [7:0] data, input bit alignTick);
    tbBus = data; tbBusEn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    if (alignTick) begin
      repeat (SYNC) @(negedge clk);
      tick1s = 1'b1;
      @(negedge clk);
      tick1s = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (SYNC + 2) @(negedge clk);
    end
    tbBusEn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
    writeAddr(addr);
    writeData(data, 1'b0);
  endtask

  // The bus must still float SYNC cycles after RDI falls and be driven one cycle later.
  task automatic readCheck(input logic [7:0] addr, input logic [7:0] expected, input string tag);
    writeAddr(addr);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (SYNC) @(negedge clk);
    checkOutput({tag, "_hiz_pre"}, busLine, 8'hFF);
    @(negedge clk);
    checkOutput(tag, busLine, expected);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
    checkOutput({tag, "_hiz_post"}, busLine, 8'hFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (SYNC) @(negedge clk);
  endtask

  task automatic tickOnce();
    @(negedge clk);
    tick1s = 1'b1;
    @(negedge clk);
    tick1s = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_irq", {7'd0, irqN}, 8'h01);
    checkOutput("rst_bus", busLine, 8'hFF);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    readCheck(ADDR_SEC,    8'h00, "rst_sec");
    readCheck(ADDR_DAY,    8'h01, "rst_day");
    readCheck(ADDR_MONTH,  8'h01, "rst_month");
    readCheck(ADDR_YEAR,   8'h00, "rst_year");
    readCheck(ADDR_STATUS, 8'h00, "rst_status");

    writeReg(ADDR_SEC, 8'h45);
    readCheck(ADDR_SEC, 8'h45, "wr_sec_45");

    writeReg(ADDR_SEC,   8'h59);
    writeReg(ADDR_MIN,   8'h59);
    writeReg(ADDR_HOUR,  8'h23);
    writeReg(ADDR_DAY,   8'h31);
    writeReg(ADDR_MONTH, 8'h12);
    writeReg(ADDR_YEAR,  8'h99);
    tickOnce();
    readCheck(ADDR_SEC,   8'h00, "roll_sec");
    readCheck(ADDR_MIN,   8'h00, "roll_min");
    readCheck(ADDR_HOUR,  8'h00, "roll_hour");
    readCheck(ADDR_DAY,   8'h01, "roll_day");
    readCheck(ADDR_MONTH, 8'h01, "roll_month");
    readCheck(ADDR_YEAR,  8'h00, "roll_year");
    checkOutput("roll_irq", {7'd0, irqN}, 8'h01);

    writeAddr(ADDR_SEC);
    writeData(8'h10, 1'b1);
    readCheck(ADDR_SEC, 8'h11, "wr_tick_sec");
    readCheck(ADDR_MIN, 8'h00, "wr_tick_min");

    writeReg(ADDR_TMR_SEC, 8'h02);
    tickOnce();
    checkOutput("tmr_irq_1", {7'd0, irqN}, 8'h01);
    readCheck(ADDR_TMR_SEC, 8'h01, "tmr_sec_1");
    tickOnce();
    checkOutput("tmr_irq_0", {7'd0, irqN}, 8'h00);
    readCheck(ADDR_TMR_SEC, 8'h00, "tmr_sec_0");
    readCheck(ADDR_STATUS,  8'h01, "tmr_status_set");
    writeReg(ADDR_STATUS, 8'h5A);
    checkOutput("tmr_irq_clr", {7'd0, irqN}, 8'h01);
    readCheck(ADDR_STATUS, 8'h00, "tmr_status_clr");
    tickOnce();
    checkOutput("tmr_zero_irq", {7'd0, irqN}, 8'h01);
    readCheck(ADDR_TMR_SEC, 8'h00, "tmr_zero_stays");

    writeReg(ADDR_TMR_HOUR, 8'h01);
    tickOnce();
    readCheck(ADDR_TMR_HOUR, 8'h00, "tmr_borrow_h");
    readCheck(ADDR_TMR_MIN,  8'h59, "tmr_borrow_m");
    readCheck(ADDR_TMR_SEC,  8'h59, "tmr_borrow_s");
    checkOutput("tmr_borrow_irq", {7'd0, irqN}, 8'h01);

    writeReg(ADDR_MIN, 8'h15);
    writeAddr(ADDR_MIN);
    tbBus = 8'h33; tbBusEn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (SYNC + 2) @(negedge clk);
    tbBusEn = 1'b0;
    readCheck(ADDR_MIN, 8'h15, "cs_abort_min");
    readCheck(8'h7F, 8'hFF, "unmapped_rd");
    writeReg(8'h7F, 8'h12);
    readCheck(8'h7F, 8'hFF, "unmapped_wr");
    readCheck(ADDR_SEC, 8'h15, "unmapped_sec");

    writeReg(ADDR_HOUR, 8'h12);
    writeAddr(ADDR_HOUR);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (SYNC + 1) @(negedge clk);
    checkOutput("midrd_driven", busLine, 8'h12);
    #1 resetN = 1'b0;
    #1 checkOutput("midrd_hiz", busLine, 8'hFF);
    @(negedge clk);
    csi = 1'b1; adi = 1'b0; wri = 1'b1; rdi = 1'b1;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrd_irq", {7'd0, irqN}, 8'h01);
    readCheck(ADDR_HOUR,     8'h00, "midrd_hour");
    readCheck(ADDR_MIN,      8'h00, "midrd_min");
    readCheck(ADDR_SEC,      8'h00, "midrd_sec");
    readCheck(ADDR_DAY,      8'h01, "midrd_day");
    readCheck(ADDR_MONTH,    8'h01, "midrd_month");
    readCheck(ADDR_YEAR,     8'h00, "midrd_year");
    readCheck(ADDR_TMR_MIN,  8'h00, "midrd_tmr_min");
    readCheck(ADDR_TMR_SEC,  8'h00, "midrd_tmr_sec");
    readCheck(ADDR_STATUS,   8'h00, "midrd_status");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth for CSI/ADI/RDI/WRI.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CSI  input  1  chip select, active-low, from the bus controller.
REQ-005 SHALL have port ADI  input  1  address/data select: 0 = address phase, 1 = data phase.
REQ-006 SHALL have port WRI  input  1  write strobe, active-low.
REQ-007 SHALL have port RDI  input  1  read strobe, active-low.
REQ-008 SHALL have port Bus_Dato_Dir  inout  8  multiplexed address/data bus; driven only per REQ-016.
REQ-009 SHALL have port tick_1s  input  1  one-CLK pulse per second; timekeeping enable.
REQ-010 SHALL have port irq_n  output  1  low while the timer-done flag is set.

Function
REQ-011 SHALL pass CSI/ADI/WRI/RDI through SYNC_STAGES flops; all bus decoding uses synchronized copies only.
REQ-012 SHALL implement bus FSM IDLE, ADDR, WR_DATA, RD_DATA: IDLE->ADDR on CS=0,AD=0,WR fall; ADDR->IDLE on WR rise, latching Bus_Dato_Dir into addr_q.
REQ-013 SHALL go IDLE->WR_DATA on CS=0,AD=1,WR fall; on WR rise, write bus byte to register addr_q, return to IDLE.
REQ-014 SHALL go IDLE->RD_DATA on CS=0,AD=1,RD fall; capture register addr_q into rd_buf that cycle; return to IDLE on RD rise or CS rise.
REQ-015 SHALL return any state to IDLE with no register write when CS rises mid-phase.
REQ-016 SHALL drive Bus_Dato_Dir = rd_buf only in RD_DATA, else high-Z; first driven cycle = SYNC_STAGES+1 CLK after RDI falls.
REQ-017 SHALL map: 0x00 status (bit0 timer_done), 0x21 seconds, 0x22 minutes, 0x23 hours, 0x24 day, 0x25 month, 0x26 year, 0x41 timer seconds, 0x42 timer minutes, 0x43 timer hours; all BCD.
REQ-018 SHALL return 0xFF on reads of unmapped addresses and ignore writes to them.
REQ-019 SHALL clear timer_done on any write to 0x00, regardless of data.
REQ-020 SHALL on tick_1s increment seconds 00..59, carry to minutes 00..59, hours 00..23, day 01..31, month 01..12, year 00..99 (wraps to 00); month length not modelled.
REQ-021 SHALL on tick_1s decrement a nonzero timer (h:m:s BCD, borrow 00->59); transition to 00:00:00 sets timer_done; a zero timer stays zero.
REQ-022 SHALL give a bus write priority over tick_1s in the same cycle: tick held pending and applied on the next cycle.
REQ-023 SHALL store written bytes unchanged (no BCD range check); counting from an illegal value wraps on the next carry compare (>= limit -> reset value).

Reset
REQ-024 SHALL on Reset=0 set FSM IDLE, addr_q 0x00, rd_buf 0x00, synchronizers 1, pending tick 0, time regs 00:00:00, day 0x01, month 0x01, year 0x00, timer 00:00:00, timer_done 0, irq_n 1, bus high-Z.
REQ-025 SHALL abort any in-progress bus phase on reset without a register write.

Structure
REQ-026 SHALL place address constants, BCD limits and FSM state encoding in package rtc_resp_pkg.
REQ-027 SHALL use sub-module bcd_pair_cnt (2-digit BCD up/down counter, programmable min/max, load, carry/borrow out), instantiated per field.

Verification
REQ-028 Addr 0x21, write 0x45, read 0x21 -> bus = 0x45 in read phase, high-Z otherwise.
REQ-029 Time 23:59:59, 0x31/0x12/0x99, one tick -> 00:00:00, day 0x01, month 0x01, year 0x00.
REQ-030 Timer 00:00:02, two ticks -> 00:00:00, irq_n low after second tick; write 0x00 to addr 0x00 -> irq_n high.
REQ-031 Write to 0x21 with tick_1s in the same cycle -> written value, then +1 on next cycle (e.g. 0x10 -> 0x11).
REQ-032 CS rises during WR_DATA to 0x22 -> minutes unchanged, FSM IDLE; read of 0x7F -> 0xFF.
REQ-033 Reset asserted mid-read of 0x23 -> bus high-Z immediately, all registers at REQ-024 values.
